load_store_unit: RTL

- Sits between the execute stage and the byte-addressed, little-endian data memory.
- Accepts one load or store request at a time over a valid/ready handshake.
- Word stores go to memory directly. Byte and halfword stores use a read-modify-write sequence, because the memory writes whole words only.
- Loads return the selected byte, halfword or word, sign- or zero-extended. Misaligned or invalid accesses return an error and never touch memory.

---
 rtl/load_store_unit_if.sv | 37 +++
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: bundles the execute-side request/response handshake and
// the word-wide data-memory port of the load/store unit.
//   slave  modport : the load/store unit itself
//   master modport : the environment (execute stage + data memory)
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : request channel
//   rsp_valid/rsp_rdata/rsp_err                              : response pulse
//   mem_A/mem_WD/mem_WE/mem_RD                               : memory port
interface load_store_unit_if #(
  parameter int unsigned Width = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [Width-1:0] req_addr;
  logic [Width-1:0] req_wdata;

  logic             rsp_valid;
  logic [Width-1:0] rsp_rdata;
  logic             rsp_err;

  logic [Width-1:0] mem_A;
  logic [Width-1:0] mem_WD;
  logic             mem_WE;
  logic [Width-1:0] mem_RD;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WD, mem_WE
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: sits between the execute stage and a byte-addressed,
// little-endian, word-wide data memory. One request at a time; word stores
// write directly, byte/halfword stores do read-modify-write, loads return the
// selected lane sign- or zero-extended. Misaligned/invalid accesses respond
// with an error and never touch memory.
// Ports:
//   CLK  : clock, all state changes on the rising edge
//   RST  : synchronous active-high reset
//   bus  : load_store_unit_if.slave (request, response and memory port)
module load_store_unit #(
  parameter int unsigned Width = 32
) (
  input  logic                CLK,
  input  logic                RST,
  load_store_unit_if.slave    bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LD    = 3'd1;
  localparam logic [2:0] ST_RD = 3'd2;
  localparam logic [2:0] ST_WR = 3'd3;
  localparam logic [2:0] RSP   = 3'd4;

  logic [2:0]       state_q,  state_d;
  logic             we_q,     we_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [Width-1:0] addr_q,   addr_d;
  logic [Width-1:0] wdata_q,  wdata_d;
  logic [Width-1:0] merge_q,  merge_d;
  logic [Width-1:0] rdata_q,  rdata_d;
  logic             err_q,    err_d;

  logic             accept;
  logic             req_err;
  logic [Width-1:0] lane_word;
  logic [Width-1:0] load_data;
  logic [Width-1:0] store_word;

  assign accept = bus.req_valid && (state_q == IDLE);

  // Request legality, decoded from the live request so an error can respond
  // one cycle after accept without a separate decode state.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = bus.req_addr[0];
      3'b010:  req_err = |bus.req_addr[1:0];
      3'b100:  req_err = bus.req_we;
      3'b101:  req_err = bus.req_we | bus.req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  // Selected lane shifted down to bit 0; word accesses are aligned so the
  // shift is zero for them.
  assign lane_word = bus.mem_RD >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = lane_word;
    case (funct3_q)
      3'b000:  load_data = {{(Width-8){lane_word[7]}},   lane_word[7:0]};
      3'b001:  load_data = {{(Width-16){lane_word[15]}}, lane_word[15:0]};
      3'b100:  load_data = {{(Width-8){1'b0}},           lane_word[7:0]};
      3'b101:  load_data = {{(Width-16){1'b0}},          lane_word[15:0]};
      default: load_data = lane_word;
    endcase
  end

  // Merge store data into the word captured in ST_RD.
  always_comb begin
    store_word = merge_q;
    case (funct3_q[1:0])
      2'b00:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: store_word = wdata_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          if (req_err) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RSP;
          end else if (!bus.req_we) begin
            state_d = LD;
          end else if (bus.req_funct3 == 3'b010) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      LD: begin
        rdata_d = load_data;
        err_d   = 1'b0;
        state_d = RSP;
      end
      ST_RD: begin
        merge_d = bus.mem_RD;
        state_d = ST_WR;
      end
      ST_WR: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = RSP;
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Handshake and strobe outputs are gated by RST so a reset cycle can
  // neither accept, respond nor write, whatever state it interrupts.
  assign bus.req_ready = (state_q == IDLE) && !RST;
  assign bus.rsp_valid = (state_q == RSP) && !RST;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_A     = {addr_q[Width-1:2], 2'b00};
  assign bus.mem_WE    = (state_q == ST_WR) && !RST;
  assign bus.mem_WD    = (state_q == ST_WR) ? store_word : '0;

  // we_q is kept for completeness of the captured request; the state
  // sequence already encodes load vs store.
  logic unused_we;
  assign unused_we = we_q;

endmodule
